// File: rtl/morse_decode_ctrl_pkg.sv
// rtl/morse_decode_ctrl_pkg.sv - shared character-code defines and buffer-shift types for morse_decode_ctrl
`ifndef MORSE_DEFINES_SVH
`define MORSE_DEFINES_SVH
`define CHAR_W          6
`define CHAR_CODE_SPACE 6'h00
`define CHAR_CODE_ERR   6'h3F
`endif

package morse_decode_ctrl_pkg;

    localparam int CHAR_BITS = `CHAR_W;
    localparam logic [CHAR_BITS-1:0] CODE_SPACE = `CHAR_CODE_SPACE;
    localparam logic [CHAR_BITS-1:0] CODE_ERR   = `CHAR_CODE_ERR;

    typedef enum logic [1:0] {
        SH_NONE,
        SH_CHAR,
        SH_SPACE,
        SH_ERR
    } shift_t;

endpackage

// File: rtl/morse_tick_gen.sv
// rtl/morse_tick_gen.sv - free-running clock-enable divider, held at zero while run is low
module morse_tick_gen #(
    parameter int TICK_DIV = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/morse_decode_ctrl.sv
// rtl/morse_decode_ctrl.sv - morse decode controller with scrolling display buffer
// Optional: define MORSE_CTRL_ERRCHAR_EN to insert the error code into the buffer on cap_error.
module morse_decode_ctrl
    import morse_decode_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 500000,
    parameter int DISP_LEN = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       clear,
    input  logic                       cap_char_end,
    input  logic                       cap_word_end,
    input  logic                       cap_error,
    input  logic [`CHAR_W-1:0]         char_in,
    output logic                       cap_start,
    output logic                       cap_ce,
    output logic [DISP_LEN*`CHAR_W-1:0] disp,
    output logic [2:0]                 count,
    output logic                       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        LISTEN,
        COMMIT,
        SPACE
    } state_t;

    localparam logic [2:0] CNT_MAX = 3'(DISP_LEN);

    state_t state, state_nxt;
    logic   word_pend, word_pend_nxt;
    shift_t shift_op;
    logic   do_shift;
    logic [CHAR_BITS-1:0] shift_code;

    logic [DISP_LEN-1:0][CHAR_BITS-1:0] buf_q;
    logic [2:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            word_pend <= word_pend_nxt;
        end
    end

    // The buffer shift is issued on the edge that leaves LISTEN, so disp
    // follows a strobe by exactly one clock; COMMIT/SPACE are the settle cycles.
    always_comb begin
        state_nxt     = state;
        word_pend_nxt = word_pend;
        shift_op      = SH_NONE;
        if (!enable) begin
            state_nxt     = IDLE;
            word_pend_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt     = ARM;
                    word_pend_nxt = 1'b0;
                end
                ARM: state_nxt = LISTEN;
                LISTEN: begin
                    if (cap_error) begin
                        state_nxt = ARM;
`ifdef MORSE_CTRL_ERRCHAR_EN
                        shift_op  = SH_ERR;
`endif
                    end else if (cap_char_end) begin
                        state_nxt     = COMMIT;
                        shift_op      = SH_CHAR;
                        word_pend_nxt = cap_word_end;
                    end else if (cap_word_end) begin
                        state_nxt = SPACE;
                        shift_op  = SH_SPACE;
                    end
                end
                COMMIT: begin
                    word_pend_nxt = 1'b0;
                    if (word_pend) begin
                        state_nxt = SPACE;
                        shift_op  = SH_SPACE;
                    end else begin
                        state_nxt = LISTEN;
                    end
                end
                SPACE:   state_nxt = LISTEN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        do_shift   = 1'b0;
        shift_code = char_in;
        case (shift_op)
            SH_CHAR: begin
                do_shift   = 1'b1;
                shift_code = char_in;
            end
            SH_SPACE: begin
                do_shift   = (count_q != 3'd0) && (buf_q[0] != CODE_SPACE);
                shift_code = CODE_SPACE;
            end
            SH_ERR: begin
                do_shift   = 1'b1;
                shift_code = CODE_ERR;
            end
            default: begin
                do_shift   = 1'b0;
                shift_code = char_in;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= {DISP_LEN{CODE_SPACE}};
            count_q <= 3'd0;
        end else if (clear) begin
            buf_q   <= {DISP_LEN{CODE_SPACE}};
            count_q <= 3'd0;
        end else if (do_shift) begin
            buf_q <= {buf_q[DISP_LEN-2:0], shift_code};
            if (count_q != CNT_MAX) begin
                count_q <= count_q + 3'd1;
            end
        end
    end

    morse_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (enable && (state != IDLE)),
        .tick (cap_ce)
    );

    assign cap_start = (state == ARM);
    assign busy      = (state != IDLE);
    assign disp      = buf_q;
    assign count     = count_q;

endmodule

// File: tb/tb_morse_decode_ctrl.sv
// tb/tb_morse_decode_ctrl.sv - self-checking bench for morse_decode_ctrl (vector table plus randomized queue model)
module tb_morse_decode_ctrl;
    import morse_decode_ctrl_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int DISP_LEN = 6;
    localparam int DW = DISP_LEN * CHAR_BITS;

    logic clk = 1'b0;
    logic rst_n;
    logic enable, clear, cap_char_end, cap_word_end, cap_error;
    logic [CHAR_BITS-1:0] char_in;
    logic cap_start, cap_ce, busy;
    logic [DW-1:0] disp;
    logic [2:0] count;

    int n_total = 0;
    int n_pass  = 0;

    morse_decode_ctrl #(
        .TICK_DIV(TICK_DIV),
        .DISP_LEN(DISP_LEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clear       (clear),
        .cap_char_end(cap_char_end),
        .cap_word_end(cap_word_end),
        .cap_error   (cap_error),
        .char_in     (char_in),
        .cap_start   (cap_start),
        .cap_ce      (cap_ce),
        .disp        (disp),
        .count       (count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic clr, ce, we, er;
        logic [CHAR_BITS-1:0] ch;
        logic [2:0] cnt;
        logic [CHAR_BITS-1:0] s0, s1, s2;
        logic st;
    } vec_t;

    vec_t tbl[$];
    logic [CHAR_BITS-1:0] q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [CHAR_BITS-1:0] slot(input int i);
        return disp[i*CHAR_BITS +: CHAR_BITS];
    endfunction

    function automatic logic [DW-1:0] all_space();
        logic [DW-1:0] r;
        for (int i = 0; i < DISP_LEN; i++) r[i*CHAR_BITS +: CHAR_BITS] = CODE_SPACE;
        return r;
    endfunction

    task automatic m_push(input logic [CHAR_BITS-1:0] c);
        q.push_front(c);
        if (q.size() > DISP_LEN) void'(q.pop_back());
    endtask

    task automatic m_word();
        if (q.size() != 0 && q[0] != CODE_SPACE) m_push(CODE_SPACE);
    endtask

    function automatic logic [DW-1:0] m_disp();
        logic [DW-1:0] r;
        for (int i = 0; i < DISP_LEN; i++)
            r[i*CHAR_BITS +: CHAR_BITS] = (i < q.size()) ? q[i] : CODE_SPACE;
        return r;
    endfunction

    task automatic idle_inputs();
        clear = 0; cap_char_end = 0; cap_word_end = 0; cap_error = 0;
    endtask

    // one strobe cycle from LISTEN, then enough idle cycles to be back in LISTEN
    task automatic txn(input logic clr, input logic ce, input logic we, input logic er,
                       input logic [CHAR_BITS-1:0] ch);
        clear = clr; cap_char_end = ce; cap_word_end = we; cap_error = er; char_in = ch;
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 0; enable = 0; char_in = '0;
        idle_inputs();

        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_count", 64'(count), 64'd0);
        check("reset_disp", 64'(disp), 64'(all_space()));
        check("reset_cap_start", 64'(cap_start), 64'd0);
        check("reset_cap_ce", 64'(cap_ce), 64'd0);

        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("idle_cap_ce", 64'(cap_ce), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
        end

        enable = 1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            check($sformatf("tick_cap_start_c%0d", k), 64'(cap_start), 64'(k == 1));
            check($sformatf("tick_cap_ce_c%0d", k), 64'(cap_ce), 64'(k % TICK_DIV == 0));
        end

        cap_char_end = 1; char_in = 6'd9;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        check("pre_reset_count", 64'(count), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        check("async_reset_disp", 64'(disp), 64'(all_space()));
        check("async_reset_count", 64'(count), 64'd0);
        check("async_reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        enable = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        //          clr ce we er ch      cnt   s0          s1          s2          st
        tbl.push_back('{0, 1, 0, 0, 6'd1, 3'd1, 6'd1, CODE_SPACE, CODE_SPACE, 0});
        tbl.push_back('{0, 0, 0, 0, 6'd0, 3'd1, 6'd1, CODE_SPACE, CODE_SPACE, 0});
        tbl.push_back('{0, 1, 0, 0, 6'd2, 3'd2, 6'd2, 6'd1, CODE_SPACE, 0});
        tbl.push_back('{0, 0, 0, 0, 6'd0, 3'd2, 6'd2, 6'd1, CODE_SPACE, 0});
        tbl.push_back('{0, 1, 0, 0, 6'd3, 3'd3, 6'd3, 6'd2, 6'd1, 0});
        tbl.push_back('{0, 0, 0, 0, 6'd0, 3'd3, 6'd3, 6'd2, 6'd1, 0});
        tbl.push_back('{0, 1, 1, 0, 6'd4, 3'd4, 6'd4, 6'd3, 6'd2, 0});
        tbl.push_back('{0, 0, 0, 0, 6'd0, 3'd5, CODE_SPACE, 6'd4, 6'd3, 0});
        tbl.push_back('{0, 0, 0, 0, 6'd0, 3'd5, CODE_SPACE, 6'd4, 6'd3, 0});
        tbl.push_back('{0, 0, 1, 0, 6'd0, 3'd5, CODE_SPACE, 6'd4, 6'd3, 0});
        tbl.push_back('{0, 0, 0, 0, 6'd0, 3'd5, CODE_SPACE, 6'd4, 6'd3, 0});
`ifdef MORSE_CTRL_ERRCHAR_EN
        tbl.push_back('{0, 0, 0, 1, 6'd0, 3'd6, CODE_ERR, CODE_SPACE, 6'd4, 1});
        tbl.push_back('{0, 0, 0, 0, 6'd0, 3'd6, CODE_ERR, CODE_SPACE, 6'd4, 0});
        tbl.push_back('{0, 1, 0, 0, 6'd5, 3'd6, 6'd5, CODE_ERR, CODE_SPACE, 0});
        tbl.push_back('{0, 0, 0, 0, 6'd0, 3'd6, 6'd5, CODE_ERR, CODE_SPACE, 0});
`else
        tbl.push_back('{0, 0, 0, 1, 6'd0, 3'd5, CODE_SPACE, 6'd4, 6'd3, 1});
        tbl.push_back('{0, 0, 0, 0, 6'd0, 3'd5, CODE_SPACE, 6'd4, 6'd3, 0});
        tbl.push_back('{0, 1, 0, 0, 6'd5, 3'd6, 6'd5, CODE_SPACE, 6'd4, 0});
        tbl.push_back('{0, 0, 0, 0, 6'd0, 3'd6, 6'd5, CODE_SPACE, 6'd4, 0});
`endif
        tbl.push_back('{1, 1, 0, 0, 6'd6, 3'd0, CODE_SPACE, CODE_SPACE, CODE_SPACE, 0});
        tbl.push_back('{0, 0, 0, 0, 6'd0, 3'd0, CODE_SPACE, CODE_SPACE, CODE_SPACE, 0});
        tbl.push_back('{0, 0, 1, 0, 6'd0, 3'd0, CODE_SPACE, CODE_SPACE, CODE_SPACE, 0});
        tbl.push_back('{0, 0, 0, 0, 6'd0, 3'd0, CODE_SPACE, CODE_SPACE, CODE_SPACE, 0});

        enable = 1;
        repeat (2) @(negedge clk);
        foreach (tbl[i]) begin
            clear = tbl[i].clr; cap_char_end = tbl[i].ce; cap_word_end = tbl[i].we;
            cap_error = tbl[i].er; char_in = tbl[i].ch;
            @(negedge clk);
            check($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].cnt));
            check($sformatf("vec%0d_slot0", i), 64'(slot(0)), 64'(tbl[i].s0));
            check($sformatf("vec%0d_slot1", i), 64'(slot(1)), 64'(tbl[i].s1));
            check($sformatf("vec%0d_slot2", i), 64'(slot(2)), 64'(tbl[i].s2));
            check($sformatf("vec%0d_cap_start", i), 64'(cap_start), 64'(tbl[i].st));
        end
        idle_inputs();

        cap_char_end = 1; char_in = 6'd7;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        enable = 0; cap_char_end = 1; char_in = 6'd8;
        @(negedge clk);
        idle_inputs();
        check("disable_busy", 64'(busy), 64'd0);
        check("disable_keep_count", 64'(count), 64'd1);
        check("disable_keep_slot0", 64'(slot(0)), 64'd7);
        @(negedge clk);
        check("disable_idle_cap_ce", 64'(cap_ce), 64'd0);

        enable = 1;
        repeat (2) @(negedge clk);
        txn(1, 0, 0, 0, '0);
        q.delete();
        check("rand_clear_count", 64'(count), 64'd0);

        for (int i = 0; i < 8; i++) begin
            logic [CHAR_BITS-1:0] c;
            c = CHAR_BITS'($urandom_range(1, 62));
            txn(0, 1, 0, 0, c);
            m_push(c);
        end
        check("sat_count", 64'(count), 64'(DISP_LEN));
        check("sat_disp", 64'(disp), 64'(m_disp()));

        for (int i = 0; i < 40; i++) begin
            int kind;
            logic [CHAR_BITS-1:0] c;
            kind = $urandom_range(0, 9);
            c = CHAR_BITS'($urandom_range(1, 62));
            if (kind <= 3) begin
                txn(0, 1, 0, 0, c); m_push(c);
            end else if (kind <= 5) begin
                txn(0, 0, 1, 0, c); m_word();
            end else if (kind <= 7) begin
                txn(0, 1, 1, 0, c); m_push(c); m_word();
            end else if (kind == 8) begin
                txn(0, 0, 0, 1, c);
`ifdef MORSE_CTRL_ERRCHAR_EN
                m_push(CODE_ERR);
`endif
            end else begin
                txn(1, 1, 0, 0, c); q.delete();
            end
            check($sformatf("rand%0d_k%0d_count", i, kind), 64'(count), 64'(q.size()));
            check($sformatf("rand%0d_k%0d_disp", i, kind), 64'(disp), 64'(m_disp()));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/morse_decode_ctrl.md
MORSE_DECODE_CTRL -- requirements
Module: morse_decode_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500000, meaning clk cycles per capture clock-enable tick (minimum 2).
REQ-002 SHALL have parameter DISP_LEN, default 6, meaning number of character slots in the scrolling display buffer.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, which runs decoding while high.
REQ-006 SHALL have port clear, input, 1, a synchronous pulse that empties the buffer.
REQ-007 SHALL have port cap_char_end, input, 1, the capture character-boundary strobe.
REQ-008 SHALL have port cap_word_end, input, 1, the capture word-boundary strobe.
REQ-009 SHALL have port cap_error, input, 1, the capture malformed-symbol strobe.
REQ-010 SHALL have port char_in, input, `CHAR_W, the recognized character code.
REQ-011 SHALL have port cap_start, output, 1, a one-cycle pulse that restarts the capture block.
REQ-012 SHALL have port cap_ce, output, 1, the capture clock-enable tick.
REQ-013 SHALL have port disp, output, DISP_LEN*`CHAR_W, the display buffer; slot 0 (LSBs) is newest.
REQ-014 SHALL have port count, output, 3, the number of valid slots, saturating at DISP_LEN.
REQ-015 SHALL have port busy, output, 1, high in every state other than IDLE.

Function
REQ-016 SHALL implement the states IDLE, ARM, LISTEN, COMMIT and SPACE.
REQ-017 SHALL move IDLE->ARM when enable=1; ARM asserts cap_start for exactly 1 cycle, then ->LISTEN.
REQ-018 SHALL, in LISTEN, go ->COMMIT on cap_char_end and ->SPACE on cap_word_end; if both are high in one cycle, it SHALL go COMMIT then SPACE.
REQ-019 SHALL, in COMMIT, shift char_in into slot 0, move older slots up one, discard slot DISP_LEN-1, then ->LISTEN (or ->SPACE if a word_end is pending).
REQ-020 SHALL, in SPACE, shift `CHAR_CODE_SPACE into slot 0, then ->LISTEN.
REQ-021 SHALL not insert a space when slot 0 already holds `CHAR_CODE_SPACE or when count=0.
REQ-022 SHALL apply 1 cycle of latency from a strobe to the disp update: the strobe is seen in cycle n and disp changes at edge n+1.
REQ-023 SHALL, on cap_error in LISTEN, ->ARM to re-issue cap_start; buffer behaviour on error is set in the Configuration section.
REQ-024 SHALL, when enable falls, return to IDLE from any state at the next edge, keeping the buffer.
REQ-025 SHALL, on clear, zero the buffer to `CHAR_CODE_SPACE and set count=0; clear SHALL win over a simultaneous commit.
REQ-026 SHALL, when enable=1, pulse cap_ce high 1 cycle every TICK_DIV cycles, counting 0..TICK_DIV-1 and wrapping; the counter SHALL be held at 0 in IDLE.
REQ-027 SHALL ignore strobes received in IDLE or ARM.

Reset
REQ-028 SHALL, on rst_n low, force state=IDLE, every disp slot=`CHAR_CODE_SPACE, count=0, cap_start=0, cap_ce=0, busy=0 and tick counter=0, with no clock required.
REQ-029 SHALL release reset synchronously to clk; an operation cut off by reset SHALL be dropped.

Configuration
REQ-030 SHALL, when MORSE_CTRL_ERRCHAR_EN is defined, shift `CHAR_CODE_ERR into slot 0 on cap_error (1 cycle, like COMMIT) before ->ARM.
REQ-031 SHALL, when MORSE_CTRL_ERRCHAR_EN is undefined, leave the buffer and count unchanged on cap_error.

Structure
REQ-032 SHALL take CHAR_W, CHAR_CODE_SPACE and CHAR_CODE_ERR from the shared defines header; state encoding SHALL stay local.
REQ-033 SHALL put the tick divider in a sub-module morse_tick_gen (ports: clk, rst_n, run, tick).

Verification
REQ-034 SHALL check reset: with TICK_DIV=4 and rst_n low mid-LISTEN, disp is all SPACE, count=0 and busy=0 at once, with no clk edge.
REQ-035 SHALL check ticks: with enable=1 and TICK_DIV=4, cap_start pulses once; cap_ce is high on cycles 4, 8, 12 after enable and stays 0 in IDLE.
REQ-036 SHALL check commits: with char_end strobes carrying codes 1, 2, 3, slot0=3, slot1=2, slot2=1 and count=3.
REQ-037 SHALL check boundaries: char_end and word_end in the same cycle give slot0=SPACE and slot1=char; a second word_end adds nothing; 8 commits give count=6 with the oldest 2 gone.
REQ-038 SHALL check errors: cap_error in LISTEN gives a cap_start pulse; the buffer gains ERR with the macro and is unchanged without it.
REQ-039 SHALL check clear: clear in the same cycle as char_end gives count=0 and all SPACE.
